calc2_top: RTL and testbench

CALC2_TOP -- requirements
Module: calc2_top

---
 rtl/calc2_top_if.sv | 29 ++
 rtl/calc2_top.sv | 205 ++++++++++++++++++++
 tb/tb_calc2_top.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/calc2_top_if.sv
// Bench-side bundle of every calc2_top pin, same names and widths as the block.
interface calc_if;
  logic        c_clk;
  logic        reset;
  logic [3:0]  req1_cmd_in;
  logic [3:0]  req2_cmd_in;
  logic [3:0]  req3_cmd_in;
  logic [3:0]  req4_cmd_in;
  logic [31:0] req1_data_in;
  logic [31:0] req2_data_in;
  logic [31:0] req3_data_in;
  logic [31:0] req4_data_in;
  logic [1:0]  req1_tag_in;
  logic [1:0]  req2_tag_in;
  logic [1:0]  req3_tag_in;
  logic [1:0]  req4_tag_in;
  logic [1:0]  out_resp1;
  logic [1:0]  out_resp2;
  logic [1:0]  out_resp3;
  logic [1:0]  out_resp4;
  logic [31:0] out_data1;
  logic [31:0] out_data2;
  logic [31:0] out_data3;
  logic [31:0] out_data4;
  logic [1:0]  out_tag1;
  logic [1:0]  out_tag2;
  logic [1:0]  out_tag3;
  logic [1:0]  out_tag4;
endinterface

// File: rtl/calc2_top.sv
// Four independent two-cycle ADD/SUB/SHL/SHR calculator ports.
// Define CALC2_INVALID_CMD_RESP_EN to answer undefined nonzero commands with an error.
//
// state | meaning
// IDLE  | waiting for a command; operand1 and tag latched with it
// OP2   | latching operand2; result registered on the following edge
module calc2_port #(
  parameter int DATA_W = 32
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        cmd_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        tag_i,
  output logic [1:0]        resp_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        tag_o
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OP2  = 1'b1;

  localparam logic [3:0] CMD_ADD = 4'h1;
  localparam logic [3:0] CMD_SUB = 4'h2;
  localparam logic [3:0] CMD_SHL = 4'h5;
  localparam logic [3:0] CMD_SHR = 4'h6;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  logic [0:0]        state_q, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [1:0]        tag_q, tag_d;
  logic              pend_q, pend_d;
  logic [1:0]        resp_q, resp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rtag_q, rtag_d;

  logic              cmd_known;
  logic              cmd_accept;
  logic [DATA_W:0]   sum;
  logic [1:0]        res_resp;
  logic [DATA_W-1:0] res_data;

  always_comb begin
    cmd_known = (cmd_i == CMD_ADD) || (cmd_i == CMD_SUB) ||
                (cmd_i == CMD_SHL) || (cmd_i == CMD_SHR);
`ifdef CALC2_INVALID_CMD_RESP_EN
    cmd_accept = (cmd_i != 4'h0);
`else
    cmd_accept = cmd_known;
`endif
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    tag_d   = tag_q;
    pend_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          cmd_d   = cmd_i;
          op1_d   = data_i;
          tag_d   = tag_i;
          state_d = ST_OP2;
        end
      end
      ST_OP2: begin
        op2_d   = data_i;
        pend_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Evaluated from the latched operands one edge after operand2 is taken.
  always_comb begin
    sum      = {1'b0, op1_q} + {1'b0, op2_q};
    res_resp = RESP_ERR;
    res_data = '0;
    case (cmd_q)
      CMD_ADD: begin
        if (!sum[DATA_W]) begin
          res_resp = RESP_OK;
          res_data = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (op2_q <= op1_q) begin
          res_resp = RESP_OK;
          res_data = op1_q - op2_q;
        end
      end
      CMD_SHL: begin
        res_resp = RESP_OK;
        res_data = op1_q << op2_q[4:0];
      end
      CMD_SHR: begin
        res_resp = RESP_OK;
        res_data = op1_q >> op2_q[4:0];
      end
      default: begin
        res_resp = RESP_ERR;
        res_data = '0;
      end
    endcase
  end

  always_comb begin
    resp_d  = RESP_NONE;
    rdata_d = '0;
    rtag_d  = 2'b00;
    if (pend_q) begin
      resp_d  = res_resp;
      rdata_d = (res_resp == RESP_OK) ? res_data : '0;
      rtag_d  = tag_q;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= 4'h0;
      op1_q   <= '0;
      op2_q   <= '0;
      tag_q   <= 2'b00;
      pend_q  <= 1'b0;
      resp_q  <= RESP_NONE;
      rdata_q <= '0;
      rtag_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      tag_q   <= tag_d;
      pend_q  <= pend_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      rtag_q  <= rtag_d;
    end
  end

  assign resp_o = resp_q;
  assign data_o = rdata_q;
  assign tag_o  = rtag_q;
endmodule

module calc2_top #(
  parameter int DATA_W = 32
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req1_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [1:0]        req1_tag_in,
  input  logic [3:0]        req2_cmd_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [1:0]        req2_tag_in,
  input  logic [3:0]        req3_cmd_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [1:0]        req3_tag_in,
  input  logic [3:0]        req4_cmd_in,
  input  logic [DATA_W-1:0] req4_data_in,
  input  logic [1:0]        req4_tag_in,
  output logic [1:0]        out_resp1,
  output logic [DATA_W-1:0] out_data1,
  output logic [1:0]        out_tag1,
  output logic [1:0]        out_resp2,
  output logic [DATA_W-1:0] out_data2,
  output logic [1:0]        out_tag2,
  output logic [1:0]        out_resp3,
  output logic [DATA_W-1:0] out_data3,
  output logic [1:0]        out_tag3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data4,
  output logic [1:0]        out_tag4
);
  calc2_port #(.DATA_W(DATA_W)) u_port1 (
    .c_clk(c_clk), .reset(reset),
    .cmd_i(req1_cmd_in), .data_i(req1_data_in), .tag_i(req1_tag_in),
    .resp_o(out_resp1), .data_o(out_data1), .tag_o(out_tag1)
  );
  calc2_port #(.DATA_W(DATA_W)) u_port2 (
    .c_clk(c_clk), .reset(reset),
    .cmd_i(req2_cmd_in), .data_i(req2_data_in), .tag_i(req2_tag_in),
    .resp_o(out_resp2), .data_o(out_data2), .tag_o(out_tag2)
  );
  calc2_port #(.DATA_W(DATA_W)) u_port3 (
    .c_clk(c_clk), .reset(reset),
    .cmd_i(req3_cmd_in), .data_i(req3_data_in), .tag_i(req3_tag_in),
    .resp_o(out_resp3), .data_o(out_data3), .tag_o(out_tag3)
  );
  calc2_port #(.DATA_W(DATA_W)) u_port4 (
    .c_clk(c_clk), .reset(reset),
    .cmd_i(req4_cmd_in), .data_i(req4_data_in), .tag_i(req4_tag_in),
    .resp_o(out_resp4), .data_o(out_data4), .tag_o(out_tag4)
  );
endmodule

// File: tb/tb_calc2_top.sv
// Directed self-checking bench for calc2_top, connected through calc_if.
module tb_calc2_top;
  calc_if vif ();

  logic [3:0]  cmd_a [4];
  logic [31:0] din_a [4];
  logic [1:0]  tin_a [4];
  int n_assert = 0;
  int n_fail   = 0;

  assign vif.req1_cmd_in  = cmd_a[0];
  assign vif.req2_cmd_in  = cmd_a[1];
  assign vif.req3_cmd_in  = cmd_a[2];
  assign vif.req4_cmd_in  = cmd_a[3];
  assign vif.req1_data_in = din_a[0];
  assign vif.req2_data_in = din_a[1];
  assign vif.req3_data_in = din_a[2];
  assign vif.req4_data_in = din_a[3];
  assign vif.req1_tag_in  = tin_a[0];
  assign vif.req2_tag_in  = tin_a[1];
  assign vif.req3_tag_in  = tin_a[2];
  assign vif.req4_tag_in  = tin_a[3];

  calc2_top #(.DATA_W(32)) dut (
    .c_clk(vif.c_clk), .reset(vif.reset),
    .req1_cmd_in(vif.req1_cmd_in), .req1_data_in(vif.req1_data_in), .req1_tag_in(vif.req1_tag_in),
    .req2_cmd_in(vif.req2_cmd_in), .req2_data_in(vif.req2_data_in), .req2_tag_in(vif.req2_tag_in),
    .req3_cmd_in(vif.req3_cmd_in), .req3_data_in(vif.req3_data_in), .req3_tag_in(vif.req3_tag_in),
    .req4_cmd_in(vif.req4_cmd_in), .req4_data_in(vif.req4_data_in), .req4_tag_in(vif.req4_tag_in),
    .out_resp1(vif.out_resp1), .out_data1(vif.out_data1), .out_tag1(vif.out_tag1),
    .out_resp2(vif.out_resp2), .out_data2(vif.out_data2), .out_tag2(vif.out_tag2),
    .out_resp3(vif.out_resp3), .out_data3(vif.out_data3), .out_tag3(vif.out_tag3),
    .out_resp4(vif.out_resp4), .out_data4(vif.out_data4), .out_tag4(vif.out_tag4)
  );

  initial vif.c_clk = 1'b0;
  always #5 vif.c_clk = ~vif.c_clk;

  function automatic logic [1:0] resp_of(int p);
    case (p)
      0: return vif.out_resp1;
      1: return vif.out_resp2;
      2: return vif.out_resp3;
      default: return vif.out_resp4;
    endcase
  endfunction

  function automatic logic [31:0] data_of(int p);
    case (p)
      0: return vif.out_data1;
      1: return vif.out_data2;
      2: return vif.out_data3;
      default: return vif.out_data4;
    endcase
  endfunction

  function automatic logic [1:0] tag_of(int p);
    case (p)
      0: return vif.out_tag1;
      1: return vif.out_tag2;
      2: return vif.out_tag3;
      default: return vif.out_tag4;
    endcase
  endfunction

  // Step past the next rising edge; outputs are stable 1 time unit later.
  task automatic cyc();
    @(posedge vif.c_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic exp_port(input int p, input logic [1:0] r, input logic [31:0] d,
                          input logic [1:0] t, input string name);
    chk($sformatf("%s.p%0d.resp", name, p + 1), {30'd0, resp_of(p)}, {30'd0, r});
    chk($sformatf("%s.p%0d.data", name, p + 1), data_of(p), d);
    chk($sformatf("%s.p%0d.tag", name, p + 1), {30'd0, tag_of(p)}, {30'd0, t});
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      cmd_a[i] = 4'h0;
      din_a[i] = 32'h0;
      tin_a[i] = 2'b00;
    end
  endtask

  // Drives a command at edge E and operand2 at E+1 (with a junk command that
  // must be ignored), checks silence at E+1; returns just after E+1.
  task automatic op(input int p, input logic [3:0] cmd, input logic [31:0] a,
                    input logic [31:0] b, input logic [1:0] tag, input string name);
    cmd_a[p] = cmd;
    din_a[p] = a;
    tin_a[p] = tag;
    cyc();
    cmd_a[p] = 4'h1;
    din_a[p] = b;
    tin_a[p] = 2'b11;
    cyc();
    exp_port(p, 2'b00, 32'h0, 2'b00, {name, ".e1"});
    cmd_a[p] = 4'h0;
    din_a[p] = 32'h0;
    tin_a[p] = 2'b00;
  endtask

  task automatic op_chk(input int p, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] tag,
                        input logic [1:0] er, input logic [31:0] ed, input string name);
    op(p, cmd, a, b, tag, name);
    cyc();
    exp_port(p, er, ed, tag, {name, ".e2"});
    cyc();
    exp_port(p, 2'b00, 32'h0, 2'b00, {name, ".e3"});
  endtask

  initial begin
    idle_all();
    vif.reset = 1'b1;
    cyc();
    cyc();
    for (int p = 0; p < 4; p++) exp_port(p, 2'b00, 32'h0, 2'b00, "reset");

    // Command presented for the very first edge with reset low.
    vif.reset = 1'b0;
    op_chk(0, 4'h1, 32'h1, 32'h2, 2'd2, 2'b01, 32'h3, "add_1_2");
    op_chk(0, 4'h1, 32'hFFFF_FFFF, 32'h1, 2'd3, 2'b10, 32'h0, "add_ovf");
    op_chk(0, 4'h2, 32'h5, 32'h6, 2'd1, 2'b10, 32'h0, "sub_unf");
    op_chk(0, 4'h2, 32'h6, 32'h5, 2'd0, 2'b01, 32'h1, "sub_ok");
    op_chk(0, 4'h2, 32'h7, 32'h7, 2'd2, 2'b01, 32'h0, "sub_eq");
    op_chk(0, 4'h5, 32'h1, 32'h24, 2'd1, 2'b01, 32'h10, "shl");
    op_chk(0, 4'h6, 32'h8000_0000, 32'd31, 2'd3, 2'b01, 32'h1, "shr");
    op_chk(3, 4'h1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 2'b01, 32'hFFFF_FFFF, "add_max");
    op_chk(1, 4'h5, 32'hF000_000F, 32'h4, 2'd2, 2'b01, 32'h0000_00F0, "shl_drop");

    // Back-to-back on port 2: second command accepted at E+2.
    cmd_a[1] = 4'h1; din_a[1] = 32'd10; tin_a[1] = 2'd1;
    cyc();
    cmd_a[1] = 4'h0; din_a[1] = 32'd20; tin_a[1] = 2'd0;
    cyc();
    cmd_a[1] = 4'h2; din_a[1] = 32'd100; tin_a[1] = 2'd3;
    cyc();
    exp_port(1, 2'b01, 32'd30, 2'd1, "b2b_first");
    cmd_a[1] = 4'h0; din_a[1] = 32'd1; tin_a[1] = 2'd0;
    cyc();
    exp_port(1, 2'b00, 32'h0, 2'b00, "b2b_gap");
    idle_all();
    cyc();
    exp_port(1, 2'b01, 32'd99, 2'd3, "b2b_second");
    cyc();

    // All four ports at once.
    cmd_a[0] = 4'h1; din_a[0] = 32'd7;     tin_a[0] = 2'd1;
    cmd_a[1] = 4'h2; din_a[1] = 32'd9;     tin_a[1] = 2'd2;
    cmd_a[2] = 4'h5; din_a[2] = 32'd3;     tin_a[2] = 2'd3;
    cmd_a[3] = 4'h6; din_a[3] = 32'h100;   tin_a[3] = 2'd0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      cmd_a[i] = 4'h0;
      tin_a[i] = 2'b00;
    end
    din_a[0] = 32'd8; din_a[1] = 32'd4; din_a[2] = 32'd2; din_a[3] = 32'd4;
    cyc();
    idle_all();
    cyc();
    exp_port(0, 2'b01, 32'd15, 2'd1, "quad");
    exp_port(1, 2'b01, 32'd5, 2'd2, "quad");
    exp_port(2, 2'b01, 32'd12, 2'd3, "quad");
    exp_port(3, 2'b01, 32'h10, 2'd0, "quad");
    cyc();

    // Reset while in OP2 discards the request.
    cmd_a[0] = 4'h1; din_a[0] = 32'd1; tin_a[0] = 2'd1;
    cyc();
    cmd_a[0] = 4'h0; din_a[0] = 32'd1; tin_a[0] = 2'd0;
    vif.reset = 1'b1;
    cyc();
    vif.reset = 1'b0;
    idle_all();
    cyc();
    exp_port(0, 2'b00, 32'h0, 2'b00, "rst_op2_e2");
    cyc();
    exp_port(0, 2'b00, 32'h0, 2'b00, "rst_op2_e3");
    op_chk(0, 4'h1, 32'd5, 32'd6, 2'd3, 2'b01, 32'd11, "add_after_rst");

    // Reset with the response pending also suppresses it.
    cmd_a[2] = 4'h1; din_a[2] = 32'd2; tin_a[2] = 2'd2;
    cyc();
    cmd_a[2] = 4'h0; din_a[2] = 32'd3; tin_a[2] = 2'd0;
    cyc();
    idle_all();
    vif.reset = 1'b1;
    cyc();
    exp_port(2, 2'b00, 32'h0, 2'b00, "rst_pend");
    vif.reset = 1'b0;
    cyc();
    exp_port(2, 2'b00, 32'h0, 2'b00, "rst_pend_after");

`ifdef CALC2_INVALID_CMD_RESP_EN
    op_chk(2, 4'h3, 32'h12, 32'h34, 2'd2, 2'b10, 32'h0, "inv_cmd");
`else
    // Undefined command is dropped; a valid one on the next edge is taken.
    cmd_a[2] = 4'h3; din_a[2] = 32'h12; tin_a[2] = 2'd2;
    cyc();
    cmd_a[2] = 4'h1; din_a[2] = 32'd4; tin_a[2] = 2'd1;
    cyc();
    exp_port(2, 2'b00, 32'h0, 2'b00, "inv_e1");
    cmd_a[2] = 4'h0; din_a[2] = 32'd5; tin_a[2] = 2'd0;
    cyc();
    exp_port(2, 2'b00, 32'h0, 2'b00, "inv_e2");
    idle_all();
    cyc();
    exp_port(2, 2'b01, 32'd9, 2'd1, "inv_then_add");
`endif

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
